// File: rtl/dff_seq_ctrl.sv
// dff_seq_ctrl: steps a D flip-flop under test through eleven control phases (P0..P10).
// Define DFF_SEQ_CHECK_EN to add the q_in checker outputs err_cnt and pass.
module dff_seq_ctrl #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               r_n,
    input  logic               start,
    input  logic               abort,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               q_in,
    output logic               sync,
    output logic               r,
    output logic               s,
    output logic               d,
    output logic               busy,
    output logic               done,
    output logic [3:0]         phase
`ifdef DFF_SEQ_CHECK_EN
    ,
    output logic [7:0]         err_cnt,
    output logic               pass
`endif
);
    localparam logic [3:0] P0   = 4'h0;
    localparam logic [3:0] P10  = 4'hA;
    localparam logic [3:0] DONE = 4'hE;
    localparam logic [3:0] IDLE = 4'hF;
    // {sync, r, s, d} per phase
    localparam logic [3:0] PINS [0:10] = '{4'b0000, 4'b0101, 4'b0001, 4'b0011, 4'b0001, 4'b1001,
                                           4'b1000, 4'b0000, 4'b0001, 4'b0011, 4'b0001};

    logic [3:0]         state_q, state_d, pins_q, pins_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d, cnt_q, cnt_d;
    logic               busy_q, done_q, in_ph, last, launch;

    assign in_ph  = state_q <= P10;
    assign last   = in_ph && cnt_q >= dwell_q;
    assign launch = state_q == IDLE && start && !abort;

    always_comb begin
        state_d = launch ? P0 :
                  (in_ph && abort) ? IDLE :
                  last ? (state_q == P10 ? DONE : state_q + 4'h1) :
                  (state_q == DONE) ? IDLE : state_q;
        // counter restarts at 1 on each phase entry, so it never passes the latched dwell
        cnt_d   = state_d > P10 ? '0 : state_d != state_q ? DWELL_W'(1) : cnt_q + DWELL_W'(1);
        dwell_d = launch ? (dwell == '0 ? DWELL_W'(1) : dwell) : dwell_q;
        pins_d  = state_d <= P10 ? PINS[state_d] : 4'b0000;
    end

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dwell_q <= '0;
            pins_q  <= 4'b0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            pins_q  <= pins_d;
            busy_q  <= state_d <= P10;
            done_q  <= state_d == DONE;
        end
    end

    assign {sync, r, s, d} = pins_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign phase = state_q;

`ifdef DFF_SEQ_CHECK_EN
    // expected q on the last cycle of P10..P0 (bit k = Pk)
    localparam logic [10:0] EXP_Q = 11'b111_0011_1100;

    logic [7:0] err_q, err_d;
    logic       pass_q, pass_d;

    always_comb begin
        err_d  = launch ? 8'h00 :
                 (last && q_in != EXP_Q[state_q] && err_q != 8'hFF) ? err_q + 8'h01 : err_q;
        pass_d = launch ? 1'b0 : state_d == DONE ? err_d == 8'h00 : pass_q;
    end

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            err_q  <= 8'h00;
            pass_q <= 1'b0;
        end else begin
            err_q  <= err_d;
            pass_q <= pass_d;
        end
    end

    assign err_cnt = err_q;
    assign pass    = pass_q;
`else
    logic unused_q_in;
    assign unused_q_in = q_in;
`endif
endmodule

// File: tb/tb_dff_seq_ctrl.sv
// tb_dff_seq_ctrl: vector table, directed corner cases and random traffic against a
// schedule-queue model of dff_seq_ctrl.
module tb_dff_seq_ctrl;
    typedef struct {
        logic       st;
        logic       ab;
        logic [7:0] dw;
        logic [3:0] ph;
        logic [3:0] pins;
        logic       bz;
        logic       dn;
    } vec_t;

    logic       clk = 1'b0, r_n = 1'b1, start = 1'b0, abort = 1'b0, q_in;
    logic [7:0] dwell = 8'd0;
    logic       sync, r, s, d, busy, done;
    logic [3:0] phase;
`ifdef DFF_SEQ_CHECK_EN
    logic [7:0] err_cnt;
    logic       pass;
`endif
    int   errors = 0, checks = 0;
    int   exp_ph = 15;
    int   sched[$];
    logic fq = 1'b0;
    bit   q_tied0 = 1'b0;

    dff_seq_ctrl #(.DWELL_W(8)) dut (
        .clk(clk), .r_n(r_n), .start(start), .abort(abort), .dwell(dwell), .q_in(q_in),
        .sync(sync), .r(r), .s(s), .d(d), .busy(busy), .done(done), .phase(phase)
`ifdef DFF_SEQ_CHECK_EN
        , .err_cnt(err_cnt), .pass(pass)
`endif
    );

    always #5 clk = ~clk;

    // flop under test: async reset/set over a clocked d
    always @(posedge clk) fq <= d;
    assign q_in = q_tied0 ? 1'b0 : r ? 1'b0 : s ? 1'b1 : fq;

    function automatic logic [3:0] spec_pins(input int p);
        case (p)
            1:            return 4'b0101;
            2, 4, 8, 10:  return 4'b0001;
            3, 9:         return 4'b0011;
            5:            return 4'b1001;
            6:            return 4'b1000;
            default:      return 4'b0000;
        endcase
    endfunction

    function automatic logic [9:0] model_out();
        return {4'(exp_ph), spec_pins(exp_ph), exp_ph <= 10, exp_ph == 14};
    endfunction

    function automatic logic [9:0] dut_out();
        return {phase, sync, r, s, d, busy, done};
    endfunction

    task automatic cmp(input string nm, input logic [9:0] act, input logic [9:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp_v);
        end
    endtask

    // model: a launch expands into a per-cycle list of phase codes, DONE last
    task automatic model_step();
        int len;
        if (!r_n) begin
            exp_ph = 15;
            sched.delete();
        end else if (exp_ph == 15) begin
            if (start && !abort) begin
                len = (dwell == 8'd0) ? 1 : int'(dwell);
                for (int k = 0; k <= 10; k++)
                    for (int j = 0; j < len; j++) sched.push_back(k);
                sched.push_back(14);
                exp_ph = sched.pop_front();
            end
        end else if (exp_ph == 14) begin
            exp_ph = 15;
        end else if (abort) begin
            exp_ph = 15;
            sched.delete();
        end else begin
            exp_ph = sched.pop_front();
        end
    endtask

    task automatic step(input logic st, input logic ab, input logic [7:0] dw, input string nm);
        start = st;
        abort = ab;
        dwell = dw;
        model_step();
        @(posedge clk);
        #1;
        cmp(nm, dut_out(), model_out());
    endtask

    task automatic run_seq(input logic [7:0] dw, input int want, input string nm);
        int got;
        got = -1;
        step(1'b1, 1'b0, dw, nm);
        for (int i = 1; i <= 400 && got < 0; i++) begin
            if (done) got = i;
            else step(1'b0, 1'b0, dw, nm);
        end
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, required %0d", nm, got, want);
        end
`ifdef DFF_SEQ_CHECK_EN
        if (nm == "r28") begin
            cmp("r28_err_cnt", {2'b00, err_cnt}, 10'd0);
            cmp("r28_pass", {9'd0, pass}, 10'd1);
        end
        if (nm == "r30") begin
            cmp("r30_err_cnt", {2'b00, err_cnt}, 10'd7);
            cmp("r30_pass", {9'd0, pass}, 10'd0);
        end
`endif
        step(1'b0, 1'b0, dw, {nm, "_settle"});
    endtask

    initial begin
        vec_t tv[17];
        int   n_done;
        tv[0]  = '{1'b1, 1'b0, 8'd0, 4'h0, 4'b0000, 1'b1, 1'b0};
        tv[1]  = '{1'b0, 1'b0, 8'd0, 4'h1, 4'b0101, 1'b1, 1'b0};
        tv[2]  = '{1'b0, 1'b0, 8'd0, 4'h2, 4'b0001, 1'b1, 1'b0};
        tv[3]  = '{1'b0, 1'b0, 8'd0, 4'h3, 4'b0011, 1'b1, 1'b0};
        tv[4]  = '{1'b1, 1'b0, 8'd0, 4'h4, 4'b0001, 1'b1, 1'b0};
        tv[5]  = '{1'b0, 1'b0, 8'd7, 4'h5, 4'b1001, 1'b1, 1'b0};
        tv[6]  = '{1'b0, 1'b0, 8'd0, 4'h6, 4'b1000, 1'b1, 1'b0};
        tv[7]  = '{1'b0, 1'b0, 8'd0, 4'h7, 4'b0000, 1'b1, 1'b0};
        tv[8]  = '{1'b0, 1'b0, 8'd0, 4'h8, 4'b0001, 1'b1, 1'b0};
        tv[9]  = '{1'b0, 1'b0, 8'd0, 4'h9, 4'b0011, 1'b1, 1'b0};
        tv[10] = '{1'b0, 1'b0, 8'd0, 4'hA, 4'b0001, 1'b1, 1'b0};
        tv[11] = '{1'b0, 1'b0, 8'd0, 4'hE, 4'b0000, 1'b0, 1'b1};
        tv[12] = '{1'b0, 1'b0, 8'd0, 4'hF, 4'b0000, 1'b0, 1'b0};
        tv[13] = '{1'b1, 1'b1, 8'd0, 4'hF, 4'b0000, 1'b0, 1'b0};
        tv[14] = '{1'b1, 1'b0, 8'd0, 4'h0, 4'b0000, 1'b1, 1'b0};
        tv[15] = '{1'b0, 1'b1, 8'd0, 4'hF, 4'b0000, 1'b0, 1'b0};
        tv[16] = '{1'b0, 1'b0, 8'd0, 4'hF, 4'b0000, 1'b0, 1'b0};

        #2 r_n = 1'b0;
        #1 cmp("reset_async", dut_out(), {4'hF, 4'b0000, 1'b0, 1'b0});
`ifdef DFF_SEQ_CHECK_EN
        cmp("reset_checker", {1'b0, err_cnt, pass}, 10'd0);
`endif
        @(posedge clk);
        #1 cmp("reset_hold", dut_out(), {4'hF, 4'b0000, 1'b0, 1'b0});
        r_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            start = tv[i].st;
            abort = tv[i].ab;
            dwell = tv[i].dw;
            model_step();
            @(posedge clk);
            #1 cmp($sformatf("vec%0d", i), dut_out(), {tv[i].ph, tv[i].pins, tv[i].bz, tv[i].dn});
        end

        run_seq(8'd3, 34, "r28");
        run_seq(8'd0, 12, "r29");
        q_tied0 = 1'b1;
        run_seq(8'd5, 56, "r30");
        q_tied0 = 1'b0;

        step(1'b1, 1'b0, 8'd4, "r31_run");
        for (int i = 0; i < 100 && exp_ph != 5; i++) step(1'b0, 1'b0, 8'd4, "r31_run");
        step(1'b0, 1'b1, 8'd4, "r31_abort");
        cmp("r31_idle", dut_out(), {4'hF, 4'b0000, 1'b0, 1'b0});
        n_done = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 1'b0, 8'd4, "r31_after");
            if (done) n_done++;
        end
        cmp("r31_no_done", 10'(n_done), 10'd0);

        step(1'b1, 1'b0, 8'd2, "r32_run");
        for (int i = 0; i < 100 && exp_ph != 3; i++) step(1'b0, 1'b0, 8'd2, "r32_run");
        #2 r_n = 1'b0;
        #1 cmp("r32_async_reset", dut_out(), {4'hF, 4'b0000, 1'b0, 1'b0});
        model_step();
        @(posedge clk);
        #1 r_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'd2, "r32_idle");
        run_seq(8'd2, 23, "r32_relaunch");

        n_done = 0;
        for (int i = 1; i <= 14; i++) begin
            step(1'b1, 1'b0, 8'd1, "r33_held");
            if (done) n_done++;
        end
        cmp("r33_one_done", 10'(n_done), 10'd1);
        cmp("r33_relaunch", {6'd0, phase}, 10'd0);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
                 8'($urandom_range(0, 4)), "random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dff_seq_ctrl.md
DFF_SEQ_CTRL -- requirements
Module: dff_seq_ctrl

Interface
REQ-001 Parameter: DWELL_W, default 8, width of the per-phase dwell count.
REQ-002 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: r_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: start  input  1  level; sampled in IDLE to launch a sequence.
REQ-005 Port: abort  input  1  level; aborts a running sequence.
REQ-006 Port: dwell  input  DWELL_W  cycles per phase; latched at launch.
REQ-007 Port: q_in  input  1  q output of the controlled D flip-flop.
REQ-008 Port: sync, r, s, d  output  1 each  control and data pins driven to the controlled flop; all registered.
REQ-009 Port: busy  output  1  high while in any phase P0..P10.
REQ-010 Port: done  output  1  one-cycle pulse on sequence completion.
REQ-011 Port: phase  output  4  current state code; IDLE=4'hF, P0..P10=4'h0..4'hA, DONE=4'hE.

Function
REQ-012 The FSM states SHALL be IDLE, P0..P10, DONE.
REQ-013 Phase outputs {sync,r,s,d} SHALL be: P0 0000; P1 0101; P2 0001; P3 0011; P4 0001; P5 1001; P6 1000; P7 0000; P8 0001; P9 0011; P10 0001.
REQ-014 In IDLE and DONE, sync, r, s and d SHALL all be 0.
REQ-015 IDLE SHALL go to P0 on the edge where start=1; outputs for P0 and busy=1 appear the following cycle.
REQ-016 The latched dwell value SHALL be the phase length in cycles; dwell=0 SHALL be treated as 1.
REQ-017 On the last cycle of Pk, the FSM SHALL advance to Pk+1; P10 SHALL advance to DONE.
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-019 start asserted while busy=1 SHALL be ignored; dwell changes while busy SHALL have no effect.
REQ-020 abort=1 in any phase SHALL force IDLE on the next edge, with outputs zeroed and no done pulse.
REQ-021 When abort and start are both high in IDLE, abort SHALL win and the FSM SHALL stay in IDLE.
REQ-022 The internal dwell counter SHALL reload on every phase entry and SHALL never wrap: the phase ends when the count reaches the dwell value.

Reset
REQ-023 r_n=0 SHALL immediately force IDLE with phase=4'hF, sync=r=s=d=0, busy=0, done=0, and the dwell counter at 0.
REQ-024 Reset asserted mid-sequence SHALL abandon the sequence with no done pulse; after release, a new start is required.
REQ-025 With the checker compiled in (REQ-026), reset SHALL also set err_cnt=0 and pass=0.

Configuration
REQ-026 The macro DFF_SEQ_CHECK_EN SHALL compile in output err_cnt (8 bits) and output pass (1 bit).
- With DFF_SEQ_CHECK_EN, q_in SHALL be sampled on the last cycle of each phase and compared to the expected value.
- Expected q for P0..P10 SHALL be 0,0,1,1,1,1,0,0,1,1,1.
- Each mismatch SHALL increment err_cnt, saturating at 8'hFF.
- err_cnt SHALL clear to 0 on launch.
- pass SHALL be set to (err_cnt==0) in DONE, clear on launch, and hold otherwise.
REQ-027 Without DFF_SEQ_CHECK_EN, the err_cnt and pass ports and all checker logic SHALL be absent; the sequencing behaviour SHALL be unchanged.

Verification
REQ-028 dwell=3, start pulse, q_in from a correct flop model -> each phase lasts 3 cycles, done pulses 34 cycles after start is sampled, err_cnt=0, pass=1.
REQ-029 dwell=0, start -> each phase lasts 1 cycle, done pulses 12 cycles after start is sampled.
REQ-030 dwell=5, q_in tied 0 -> err_cnt=7, pass=0 at done.
REQ-031 dwell=4, start, abort asserted during P5 -> phase=4'hF next cycle, all outputs 0, no done pulse.
REQ-032 dwell=2, r_n pulsed low during P3 -> immediate IDLE with all outputs 0; the next start runs a full sequence.
REQ-033 start held high for the whole run -> exactly one sequence, then a relaunch from IDLE the cycle after DONE.
